lfsr_chk_00: RTL and testbench

Receive-side checker for the 32-bit LFSR fault-mask stream produced by lfsr_00.
- Self-synchronises to an incoming LFSR word sequence.
- Declares lock, then predicts every following word.
- Counts word and bit mismatches, so injected or transport faults on the mask path are measurable.
- Sits at the far end of the mask path, feeding status registers.

---
 rtl/lfsr_pkg.sv | 40 ++++
 rtl/lfsr_chk_00_sat_acc.sv | 62 ++++++
 rtl/lfsr_chk_00.sv | 173 +++++++++++++++++
 tb/tb_lfsr_chk_00.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the 32-bit fault-mask LFSR generator and checker.
// The polynomial lives here only, so both ends of the mask path always
// agree on the sequence.
//   LFSR_TAPS       default feedback tap mask (x^32+x^22+x^2+x+1)
//   chk_state_t     checker FSM states
//   lfsr_next_taps  one LFSR step for an arbitrary tap mask
//   lfsr_next       one LFSR step with the default taps
//   popcount32      number of set bits in a 32-bit word
// -----------------------------------------------------------------------------
package lfsr_pkg;

   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } chk_state_t;

   function automatic logic [31:0] lfsr_next_taps(input logic [31:0] s,
                                                  input logic [31:0] taps);
      return {s[30:0], ^(s & taps)};
   endfunction

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return lfsr_next_taps(s, LFSR_TAPS);
   endfunction

   function automatic logic [5:0] popcount32(input logic [31:0] v);
      logic [5:0] c;
      c = 6'd0;
      for (int i = 0; i < 32; i++) begin
         c = c + {5'd0, v[i]};
      end
      return c;
   endfunction

endpackage : lfsr_pkg

// File: rtl/lfsr_chk_00_sat_acc.sv
// -----------------------------------------------------------------------------
// sat_acc
// Saturating accumulator: adds inc_i when inc_en_i is high and clamps at
// all-ones instead of wrapping. clr_i has priority over an increment.
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   clr_i     synchronous clear (wins over inc_en_i)
//   inc_en_i  add inc_i this cycle
//   inc_i     increment value (INC_W bits)
//   cnt_o     registered count (CNT_W bits)
// -----------------------------------------------------------------------------
module sat_acc #(
   parameter int CNT_W = 16,
   parameter int INC_W = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             inc_en_i,
   input  logic [INC_W-1:0] inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   // The sum is formed INC_W bits wider than the counter so an overflow is
   // visible and can be clamped rather than wrapping.
   localparam int SUM_W = CNT_W + INC_W;
   localparam logic [SUM_W-1:0] MAX_EXT = {{INC_W{1'b0}}, {CNT_W{1'b1}}};

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [SUM_W-1:0] sum_s;

   assign sum_s = {{INC_W{1'b0}}, cnt_q} + {{CNT_W{1'b0}}, inc_i};

   // Next count: clear, saturating add, or hold.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (inc_en_i) begin
         if (sum_s > MAX_EXT) begin
            cnt_d = {CNT_W{1'b1}};
         end else begin
            cnt_d = sum_s[CNT_W-1:0];
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule : sat_acc

// File: rtl/lfsr_chk_00.sv
// -----------------------------------------------------------------------------
// lfsr_chk_00
// Receive-side checker for the 32-bit LFSR fault-mask stream. Hunts for a
// non-zero seed, confirms LOCK_CNT consecutive correct successors, then
// free-runs its own prediction and counts word and bit mismatches. After
// UNLOCK_CNT consecutive misses it gives up and hunts again.
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   lfsr_enable   word-valid strobe
//   lfsr_mask     received LFSR word
//   clr_cnt       synchronous clear of both error counters
//   locked        high while in LOCKED
//   mismatch      1-cycle pulse: previous valid word mismatched while LOCKED
//   word_err_cnt  saturating count of mismatched words
//   bit_err_cnt   saturating count of differing bits
// -----------------------------------------------------------------------------
module lfsr_chk_00
   import lfsr_pkg::*;
#(
   parameter logic [31:0] TAPS       = LFSR_TAPS,
   parameter int          LOCK_CNT   = 4,
   parameter int          UNLOCK_CNT = 8,
   parameter int          CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             lfsr_enable,
   input  logic [31:0]      lfsr_mask,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             mismatch,
   output logic [CNT_W-1:0] word_err_cnt,
   output logic [CNT_W-1:0] bit_err_cnt
);

   localparam logic [3:0] LOCK_CNT_L   = 4'(LOCK_CNT);
   localparam logic [3:0] UNLOCK_CNT_L = 4'(UNLOCK_CNT);

   chk_state_t  state_q, state_d;
   logic [31:0] ref_q, ref_d;
   logic [3:0]  match_cnt_q, match_cnt_d;
   logic [3:0]  miss_cnt_q, miss_cnt_d;
   logic        locked_q;
   logic        mismatch_q, mismatch_d;

   logic [31:0] pred_s;
   logic [31:0] diff_s;
   logic [5:0]  diff_bits_s;
   logic        word_zero_s;
   logic        word_hit_s;
   logic [3:0]  match_inc_s;
   logic [3:0]  miss_inc_s;

   assign pred_s      = lfsr_next_taps(ref_q, TAPS);
   assign diff_s      = lfsr_mask ^ pred_s;
   assign diff_bits_s = popcount32(diff_s);
   assign word_zero_s = (lfsr_mask == 32'h0000_0000);
   assign word_hit_s  = (lfsr_mask == pred_s);
   assign match_inc_s = match_cnt_q + 4'd1;
   assign miss_inc_s  = miss_cnt_q + 4'd1;

   // Next-state logic for the hunt / sync / locked tracker.
   always_comb begin
      state_d     = state_q;
      ref_d       = ref_q;
      match_cnt_d = match_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      mismatch_d  = 1'b0;
      if (lfsr_enable) begin
         case (state_q)
            HUNT: begin
               // All-zero is the LFSR lock-up state and can never seed a chain.
               if (!word_zero_s) begin
                  ref_d       = lfsr_mask;
                  match_cnt_d = 4'd0;
                  state_d     = SYNC;
               end else begin
                  state_d     = HUNT;
               end
            end
            SYNC: begin
               if (word_hit_s) begin
                  ref_d       = lfsr_mask;
                  match_cnt_d = match_inc_s;
                  if (match_inc_s == LOCK_CNT_L) begin
                     state_d    = LOCKED;
                     miss_cnt_d = 4'd0;
                  end else begin
                     state_d    = SYNC;
                  end
               end else begin
                  match_cnt_d = 4'd0;
                  if (!word_zero_s) begin
                     ref_d   = lfsr_mask;
                  end else begin
                     state_d = HUNT;
                  end
               end
            end
            LOCKED: begin
               // Free-running prediction: the received word never reloads ref,
               // so a corrupted word cannot derail the following predictions.
               ref_d = pred_s;
               if (word_hit_s) begin
                  miss_cnt_d = 4'd0;
               end else begin
                  mismatch_d = 1'b1;
                  miss_cnt_d = miss_inc_s;
                  if (miss_inc_s == UNLOCK_CNT_L) begin
                     state_d = HUNT;
                  end else begin
                     state_d = LOCKED;
                  end
               end
            end
            default: begin
               state_d = HUNT;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Tracker state and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= HUNT;
         ref_q       <= 32'h0000_0000;
         match_cnt_q <= 4'd0;
         miss_cnt_q  <= 4'd0;
         locked_q    <= 1'b0;
         mismatch_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ref_q       <= ref_d;
         match_cnt_q <= match_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         // Derived from the next state so locked rises and falls on the
         // same edge as the state transition.
         locked_q    <= (state_d == LOCKED);
         mismatch_q  <= mismatch_d;
      end
   end

   sat_acc #(
      .CNT_W (CNT_W),
      .INC_W (1)
   ) u_word_acc (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (clr_cnt),
      .inc_en_i (mismatch_d),
      .inc_i    (1'b1),
      .cnt_o    (word_err_cnt)
   );

   sat_acc #(
      .CNT_W (CNT_W),
      .INC_W (6)
   ) u_bit_acc (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (clr_cnt),
      .inc_en_i (mismatch_d),
      .inc_i    (diff_bits_s),
      .cnt_o    (bit_err_cnt)
   );

   assign locked   = locked_q;
   assign mismatch = mismatch_q;

endmodule : lfsr_chk_00

// File: tb/tb_lfsr_chk_00.sv
// -----------------------------------------------------------------------------
// tb_lfsr_chk_00
// Directed bench for lfsr_chk_00: a vector table for lock and single/multi-bit
// faults, then hand-written sequences for loss of lock, gaps and zero words,
// counter saturation with a narrow instance, clear-vs-mismatch and reset.
// -----------------------------------------------------------------------------
module tb_lfsr_chk_00;

   typedef struct {
      logic        rst;
      logic        en;
      logic [31:0] mask;
      logic        clr;
      logic        exp_locked;
      logic        exp_mm;
      logic [15:0] exp_w;
      logic [15:0] exp_b;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        en;
   logic [31:0] mask;
   logic        clr;

   logic        locked16, mm16;
   logic [15:0] w16, b16;
   logic        locked4, mm4;
   logic [3:0]  w4, b4;

   int tests;
   int fails;

   vec_t vecs [14];

   lfsr_chk_00 dut (
      .clk          (clk),
      .rst          (rst),
      .lfsr_enable  (en),
      .lfsr_mask    (mask),
      .clr_cnt      (clr),
      .locked       (locked16),
      .mismatch     (mm16),
      .word_err_cnt (w16),
      .bit_err_cnt  (b16)
   );

   lfsr_chk_00 #(.CNT_W(4)) dut4 (
      .clk          (clk),
      .rst          (rst),
      .lfsr_enable  (en),
      .lfsr_mask    (mask),
      .clr_cnt      (clr),
      .locked       (locked4),
      .mismatch     (mm4),
      .word_err_cnt (w4),
      .bit_err_cnt  (b4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Taps 31, 21, 1, 0 written out explicitly.
   function automatic logic [31:0] tb_next(input logic [31:0] s);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
   endfunction

   task automatic drive(input logic r, input logic e, input logic [31:0] m, input logic c);
      rst  = r;
      en   = e;
      mask = m;
      clr  = c;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Sends 0x1,0x3,0x6,0xD,0x1B from HUNT; lock must appear after the 5th only.
   task automatic lock_chain(input string tag, input logic gaps);
      logic [31:0] w;
      w = 32'h1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, w, 1'b0);
         chk({tag, "_locked"}, {31'd0, locked16}, {31'd0, (i == 4)});
         chk({tag, "_mm"}, {31'd0, mm16}, 32'd0);
         if (gaps) begin
            drive(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);
            chk({tag, "_gap_locked"}, {31'd0, locked16}, {31'd0, (i == 4)});
            chk({tag, "_gap_mm"}, {31'd0, mm16}, 32'd0);
         end
         w = tb_next(w);
      end
   endtask

   initial begin
      logic [31:0] r;
      logic [31:0] s;
      logic [15:0] exp_b;
      int          misses;

      tests = 0;
      fails = 0;
      rst   = 1'b1;
      en    = 1'b0;
      mask  = 32'h0;
      clr   = 1'b0;

      //              rst   en    mask          clr   lock  mm    w       b
      vecs[0]  = '{1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
      vecs[1]  = '{1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
      vecs[2]  = '{1'b0, 1'b1, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
      vecs[3]  = '{1'b0, 1'b1, 32'h0000_0006, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
      vecs[4]  = '{1'b0, 1'b1, 32'h0000_000D, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
      vecs[5]  = '{1'b0, 1'b1, 32'h0000_001B, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0};
      vecs[6]  = '{1'b0, 1'b0, 32'h0000_0036, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0};
      vecs[7]  = '{1'b0, 1'b1, 32'h0000_0037, 1'b0, 1'b1, 1'b1, 16'd1, 16'd1};
      vecs[8]  = '{1'b0, 1'b1, 32'h0000_006D, 1'b0, 1'b1, 1'b0, 16'd1, 16'd1};
      vecs[9]  = '{1'b0, 1'b1, 32'h0000_00DB, 1'b0, 1'b1, 1'b0, 16'd1, 16'd1};
      vecs[10] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 16'd1, 16'd1};
      vecs[11] = '{1'b0, 1'b1, 32'h0000_0146, 1'b0, 1'b1, 1'b1, 16'd2, 16'd5};
      vecs[12] = '{1'b0, 1'b1, 32'h0000_036D, 1'b0, 1'b1, 1'b0, 16'd2, 16'd5};
      vecs[13] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0};

      @(posedge clk);
      #1;

      // Table: reset, lock, single-bit fault, gaps, 4-bit fault, clear.
      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].rst, vecs[i].en, vecs[i].mask, vecs[i].clr);
         chk($sformatf("vec%0d_locked", i), {31'd0, locked16}, {31'd0, vecs[i].exp_locked});
         chk($sformatf("vec%0d_mm", i), {31'd0, mm16}, {31'd0, vecs[i].exp_mm});
         chk($sformatf("vec%0d_werr", i), {16'd0, w16}, {16'd0, vecs[i].exp_w});
         chk($sformatf("vec%0d_berr", i), {16'd0, b16}, {16'd0, vecs[i].exp_b});
      end

      // Loss of lock: 8 all-ones words, then relock on a fresh seed.
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      lock_chain("lol_lock", 1'b0);
      r     = 32'h1B;
      exp_b = 16'd0;
      for (int i = 0; i < 8; i++) begin
         r     = tb_next(r);
         exp_b = exp_b + 16'($countones(32'hFFFF_FFFF ^ r));
         drive(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
         chk("lol_locked", {31'd0, locked16}, {31'd0, (i < 7)});
         chk("lol_mm", {31'd0, mm16}, 32'd1);
      end
      chk("lol_werr", {16'd0, w16}, 32'd8);
      chk("lol_berr", {16'd0, b16}, {16'd0, exp_b});
      s = 32'h0000_ACE1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, s, 1'b0);
         chk("relock_locked", {31'd0, locked16}, {31'd0, (i == 4)});
         s = tb_next(s);
      end
      chk("relock_werr_held", {16'd0, w16}, 32'd8);

      // Zero words in HUNT are ignored; gaps between chain words are harmless.
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 32'h0, 1'b0);
         chk("zero_locked", {31'd0, locked16}, 32'd0);
      end
      lock_chain("gap", 1'b1);

      // A zero word in SYNC returns to HUNT, so the count restarts.
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      drive(1'b0, 1'b1, 32'h1, 1'b0);
      drive(1'b0, 1'b1, 32'h3, 1'b0);
      drive(1'b0, 1'b1, 32'h0, 1'b0);
      drive(1'b0, 1'b1, 32'h6, 1'b0);
      drive(1'b0, 1'b1, 32'hD, 1'b0);
      drive(1'b0, 1'b1, 32'h1B, 1'b0);
      drive(1'b0, 1'b1, 32'h36, 1'b0);
      chk("synczero_not_locked", {31'd0, locked16}, 32'd0);
      drive(1'b0, 1'b1, 32'h6D, 1'b0);
      chk("synczero_locked", {31'd0, locked16}, 32'd1);

      // Saturation: 20 misses, 5 good words after every 7, narrow counters clamp.
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      lock_chain("sat_lock", 1'b0);
      r      = 32'h1B;
      misses = 0;
      while (misses < 20) begin
         for (int j = 0; j < 7 && misses < 20; j++) begin
            r = tb_next(r);
            drive(1'b0, 1'b1, r ^ 32'h1, 1'b0);
            misses++;
         end
         if (misses < 20) begin
            for (int j = 0; j < 5; j++) begin
               r = tb_next(r);
               drive(1'b0, 1'b1, r, 1'b0);
            end
         end
      end
      chk("sat_locked", {31'd0, locked16}, 32'd1);
      chk("sat_w4", {28'd0, w4}, 32'd15);
      chk("sat_b4", {28'd0, b4}, 32'd15);
      chk("sat_w16", {16'd0, w16}, 32'd20);
      chk("sat_b16", {16'd0, b16}, 32'd20);
      chk("sat_locked4", {31'd0, locked4}, 32'd1);

      // Clear coincident with a mismatch: clear wins.
      r = tb_next(r);
      drive(1'b0, 1'b1, r ^ 32'h3, 1'b1);
      chk("clr_mm", {31'd0, mm16}, 32'd1);
      chk("clr_w16", {16'd0, w16}, 32'd0);
      chk("clr_b16", {16'd0, b16}, 32'd0);
      chk("clr_w4", {28'd0, w4}, 32'd0);
      chk("clr_b4", {28'd0, b4}, 32'd0);
      r = tb_next(r);
      drive(1'b0, 1'b1, r ^ 32'h1, 1'b0);
      chk("postclr_w4", {28'd0, w4}, 32'd1);
      chk("postclr_b4", {28'd0, b4}, 32'd1);

      // Reset mid-SYNC, then a fresh chain locks on schedule.
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      drive(1'b0, 1'b1, 32'h1, 1'b0);
      drive(1'b0, 1'b1, 32'h3, 1'b0);
      drive(1'b1, 1'b1, 32'h6, 1'b0);
      chk("rst_locked", {31'd0, locked16}, 32'd0);
      chk("rst_mm", {31'd0, mm16}, 32'd0);
      chk("rst_werr", {16'd0, w16}, 32'd0);
      chk("rst_berr", {16'd0, b16}, 32'd0);
      lock_chain("rst_relock", 1'b0);

      // Reset while locked with a pending error clears everything.
      drive(1'b0, 1'b1, 32'h37, 1'b0);
      chk("lockfault_werr", {16'd0, w16}, 32'd1);
      drive(1'b1, 1'b1, 32'h6D, 1'b0);
      chk("rstlock_locked", {31'd0, locked16}, 32'd0);
      chk("rstlock_werr", {16'd0, w16}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule : tb_lfsr_chk_00
